wb_serial_tl_bridge: RTL and testbench
======================================

# wb_serial_tl_bridge

Wishbone-slave bridge between the Caravel management SoC and the ChipTop serial TileLink port. It is the parametrised successor to wiring Wishbone signals straight onto `serial_tl`. Each 32-bit Wishbone word is buffered in a FIFO and serialised into TL_W-bit beats under a proper ready/valid handshake; incoming beats are deserialised into a receive FIFO. Status flags, flush control and an interrupt are provided, and the block sits inside `user_project_wrapper`.

## Interface
- BASE_ADDR, 32'h3000_0000: block decodes `wbs_adr_i[31:4] == BASE_ADDR[31:4]`.
- TL_W, 1: serial beat width; one of 1, 2, 4, 8, 16, 32.
- DEPTH, 8: entries per FIFO; power of two, 2 to 128.

Ports:
- `wb_clk_i` in, 1: single clock for the whole block.
- `wb_rst_i` in, 1: reset, synchronous, active-high.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in, 1 each: Wishbone classic strobe, cycle and write-enable.
- `wbs_sel_i` in, 4: byte selects.
- `wbs_adr_i`, `wbs_dat_i` in, 32 each: Wishbone address and write data.
- `wbs_ack_o` out, 1: acknowledge.
- `wbs_dat_o` out, 32: read data.
- `serial_tl_bits_in_valid` out, 1; `serial_tl_bits_in_ready` in, 1: handshake for beats going to ChipTop.
- `serial_tl_bits_in_bits` out, TL_W: beat data going to ChipTop.
- `serial_tl_bits_out_valid` in, 1; `serial_tl_bits_out_ready` out, 1: handshake for beats coming from ChipTop.
- `serial_tl_bits_out_bits` in, TL_W: beat data coming from ChipTop.
- `irq` out, 1: receive interrupt, intended for `user_irq[0]`.

## Operation
Register map; the offset is `adr[3:2]`:
- 0x0 TX_DATA, write-only: pushes the full 32-bit word; `sel` is ignored.
- 0x4 RX_DATA, read-only: returns the RX FIFO head and pops it.
- 0x8 STATUS:
  - Read: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] tx_ovf, [5] rx_unf, [15:8] tx_count, [23:16] rx_count; all other bits read 0.
  - Write: W1C on [5:4].
- 0xC CTRL, RW when `sel[0]`: [0] EN, [1] FLUSH (self-clearing, reads 0), [2] IRQ_EN.

Error and control rules:
- TX_DATA write while tx_full: the word is dropped and tx_ovf is set (sticky).
- RX_DATA read while rx_empty: returns 0, no pop, rx_unf is set.
- FLUSH empties both FIFOs and aborts any partial serialiser/deserialiser word. It takes effect at the same edge as the write. Flags are unchanged.

Serialiser (TX):
- While idle, EN=1 and TX FIFO non-empty: load the head word, with BEATS = 32/TL_W.
- Drive the least-significant chunk first; advance one chunk per `valid && ready`.
- On the final-beat handshake, load the next word at the same edge, so there is no bubble.

Deserialiser (RX):
- `serial_tl_bits_out_ready = EN && rx_count < DEPTH`.
- Beats fill from the LSB upward. The completed word is pushed at the edge of the final beat.

Enable and interrupt:
- EN=0: `bits_in_valid` and `bits_out_ready` are forced to 0. A partial word's state is held and resumes when EN returns to 1.
- `irq` is registered and equals `IRQ_EN && !rx_empty`.
- Addresses outside BASE_ADDR are not acknowledged.

## Timing
- Reset: every output is 0; both FIFOs are empty; CTRL = 0; flags are 0; the serialiser and deserialiser are idle.
- Wishbone request in cycle N (`stb && cyc && !ack`):
  - `wbs_ack_o` is high for exactly one cycle, N+1.
  - `wbs_dat_o` is valid in N+1 and 0 otherwise.
  - Side effects (push, pop, flags, CTRL) occur at the N→N+1 edge.
- Latency from a TX_DATA write in cycle N to the first `bits_in_valid`: cycle N+2.
- Latency from the final RX beat in cycle M: rx_empty=0 in M+1, `irq` in M+2.
- Sustained throughput is one word per BEATS cycles while `ready`/`valid` stay high.
- Simultaneous push and pop on the same FIFO in one cycle: both happen and the count is unchanged. Push is legal only when not full before the edge; pop only when not empty.
- Reset in mid-word discards everything and returns the block to the reset state at the next edge.
- FLUSH and a TX_DATA write cannot coincide because the bus is single-ported.

## Structure
- Package `wb_serial_tl_pkg`: register offsets, STATUS/CTRL bit indices and the BEATS function.
- Sub-module `sync_fifo`: parameters WIDTH and DEPTH; push, pop, flush, full, empty, count and registered head. It is instantiated twice, once for TX and once for RX.
- The serialiser, deserialiser and register file stay in the top module.

## Test plan
- TL_W=8, TX_DATA write of 0xA1B2C3D4 with `ready` held at 1 → beats 0xD4, 0xC3, 0xB2, 0xA1 in cycles N+2 to N+5.
- TL_W=4: nine TX writes with EN=0 and DEPTH=8 → STATUS reads tx_count=8 and tx_ovf=1. Write 0x10 to STATUS → tx_ovf=0.
- TL_W=8: feed beats 0x78, 0x56, 0x34, 0x12 → rx_empty=0 in the cycle after the last beat. RX_DATA read returns 0x12345678. A second read returns 0 and sets rx_unf.
- TL_W=8, RX FIFO filled to DEPTH → `bits_out_ready`=0. One RX_DATA pop → `ready`=1 in the following cycle.
- Assert FLUSH after 2 of 4 TX beats (TL_W=8) → `bits_in_valid` drops next cycle. A fresh word then starts from its LSB chunk.
- IRQ_EN=1 and one RX word arrives → `irq`=1. Pop the word → `irq`=0 two cycles later. Assert `wb_rst_i` mid-word → all outputs are 0 next cycle.

Source files
------------

// File: rtl/wb_serial_tl_pkg.sv
// Shared register offsets, STATUS/CTRL bit positions and serialiser helpers
// for the Wishbone to serial TileLink bridge.
package wb_serial_tl_pkg;

    // Register select taken from wbs_adr_i[3:2]
    typedef enum logic [1:0] {
        REG_TX_DATA = 2'd0,
        REG_RX_DATA = 2'd1,
        REG_STATUS  = 2'd2,
        REG_CTRL    = 2'd3
    } reg_sel_e;

    // Serialiser state
    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_BUSY = 1'b1
    } ser_state_e;

    // STATUS bit positions
    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_FULL  = 2;
    localparam int ST_RX_EMPTY = 3;
    localparam int ST_TX_OVF   = 4;
    localparam int ST_RX_UNF   = 5;

    // CTRL bit positions
    localparam int CTRL_EN     = 0;
    localparam int CTRL_FLUSH  = 1;
    localparam int CTRL_IRQ_EN = 2;

    // Number of TL_W-bit beats that make up one 32-bit word
    function automatic int beats(input int tl_w);
        return 32 / tl_w;
    endfunction

endpackage

// File: rtl/wb_serial_tl_bridge_sync_fifo.sv
// Single-clock FIFO with synchronous flush, occupancy count and a head
// output read straight from the storage registers.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Pushes into a full FIFO and pops from an empty one are ignored
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Pointer and occupancy tracking; flush returns to empty
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage write
    // NOTE: the data array has no reset; an entry is only read after it has been written, so clearing it buys nothing.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/wb_serial_tl_bridge.sv
// Wishbone slave that queues 32-bit words, serialises them into TL_W-bit
// beats towards ChipTop and deserialises returning beats into an RX FIFO.
module wb_serial_tl_bridge
    import wb_serial_tl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          TL_W      = 1,
    parameter int          DEPTH     = 8
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    output logic            serial_tl_bits_in_valid,
    input  logic            serial_tl_bits_in_ready,
    output logic [TL_W-1:0] serial_tl_bits_in_bits,
    input  logic            serial_tl_bits_out_valid,
    output logic            serial_tl_bits_out_ready,
    input  logic [TL_W-1:0] serial_tl_bits_out_bits,
    output logic            irq
);

    localparam int BEATS = beats(TL_W);
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam int FCW   = $clog2(DEPTH) + 1;

    // Register file state
    logic        en_q, irq_en_q, tx_ovf_q, rx_unf_q, ack_q, irq_q;
    logic [31:0] dat_q;
    logic [31:0] status_w;

    // Bus decode
    logic     req, rd, wr, flush;
    reg_sel_e reg_sel;
    logic     unused_bits;

    assign unused_bits = ^{wbs_sel_i[3:1], wbs_adr_i[1:0]};
    assign req     = wbs_stb_i && wbs_cyc_i && !ack_q && (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign reg_sel = reg_sel_e'(wbs_adr_i[3:2]);
    assign rd      = req && !wbs_we_i;
    assign wr      = req && wbs_we_i;
    assign flush   = wr && (reg_sel == REG_CTRL) && wbs_sel_i[0] && wbs_dat_i[CTRL_FLUSH];

    // FIFO wiring
    logic           tx_push, tx_pop, tx_full, tx_empty;
    logic           rx_push, rx_pop, rx_full, rx_empty;
    logic [31:0]    tx_head, rx_head, rx_word_d;
    logic [FCW-1:0] tx_count, rx_count;

    assign tx_push = wr && (reg_sel == REG_TX_DATA) && !tx_full;
    assign rx_pop  = rd && (reg_sel == REG_RX_DATA) && !rx_empty;

    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tx_fifo (
        .clk_i(wb_clk_i), .rst_i(wb_rst_i), .flush_i(flush),
        .push_i(tx_push), .data_i(wbs_dat_i), .pop_i(tx_pop),
        .head_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_count)
    );

    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_rx_fifo (
        .clk_i(wb_clk_i), .rst_i(wb_rst_i), .flush_i(flush),
        .push_i(rx_push), .data_i(rx_word_d), .pop_i(rx_pop),
        .head_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_count)
    );

    // Serialiser
    ser_state_e       ser_state_q;
    logic [31:0]      tx_sh_q;
    logic [CNT_W-1:0] tx_beat_q;
    logic             in_fire, tx_last, tx_load;

    assign serial_tl_bits_in_valid = (ser_state_q == SER_BUSY) && en_q;
    assign serial_tl_bits_in_bits  = tx_sh_q[TL_W-1:0];
    assign in_fire = serial_tl_bits_in_valid && serial_tl_bits_in_ready;
    assign tx_last = (tx_beat_q == CNT_W'(BEATS - 1));
    // A word is loaded when idle, or on the final handshake so there is no bubble
    assign tx_load = en_q && !tx_empty && ((ser_state_q == SER_IDLE) || (in_fire && tx_last));
    assign tx_pop  = tx_load;

    // Serialiser FSM: shift out LSB chunk first, one chunk per handshake
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || flush) begin
            ser_state_q <= SER_IDLE;
            tx_sh_q     <= '0;
            tx_beat_q   <= '0;
        end else if (tx_load) begin
            ser_state_q <= SER_BUSY;
            tx_sh_q     <= tx_head;
            tx_beat_q   <= '0;
        end else if (in_fire) begin
            tx_sh_q   <= tx_sh_q >> TL_W;
            tx_beat_q <= tx_beat_q + CNT_W'(1);
            if (tx_last) ser_state_q <= SER_IDLE;
        end
    end

    // Deserialiser: beats enter at the top and shift down, so the first lands at the LSB
    logic [31:0]      rx_sh_q;
    logic [CNT_W-1:0] rx_beat_q;
    logic             out_fire, rx_last;

    assign serial_tl_bits_out_ready = en_q && !rx_full;
    assign out_fire  = serial_tl_bits_out_valid && serial_tl_bits_out_ready;
    assign rx_last   = (rx_beat_q == CNT_W'(BEATS - 1));
    assign rx_word_d = (rx_sh_q >> TL_W) | (32'(serial_tl_bits_out_bits) << (32 - TL_W));
    assign rx_push   = out_fire && rx_last;

    // Deserialiser beat accumulation
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || flush) begin
            rx_sh_q   <= '0;
            rx_beat_q <= '0;
        end else if (out_fire) begin
            rx_sh_q   <= rx_word_d;
            rx_beat_q <= rx_last ? '0 : rx_beat_q + CNT_W'(1);
        end
    end

    // STATUS read value
    always_comb begin
        // NOTE: default every bit first so no path through this block can infer a latch.
        status_w                 = '0;
        status_w[ST_TX_FULL]     = tx_full;
        status_w[ST_TX_EMPTY]    = tx_empty;
        status_w[ST_RX_FULL]     = rx_full;
        status_w[ST_RX_EMPTY]    = rx_empty;
        status_w[ST_TX_OVF]      = tx_ovf_q;
        status_w[ST_RX_UNF]      = rx_unf_q;
        status_w[15:8]           = 8'(tx_count);
        status_w[23:16]          = 8'(rx_count);
    end

    // Register file: one-cycle ack, registered read data, sticky flags, CTRL, irq
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            tx_ovf_q <= 1'b0;
            rx_unf_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            ack_q <= req;
            dat_q <= '0;
            irq_q <= irq_en_q && !rx_empty;
            if (rd) begin
                case (reg_sel)
                    REG_RX_DATA: begin
                        dat_q <= rx_empty ? 32'h0 : rx_head;
                        if (rx_empty) rx_unf_q <= 1'b1;
                    end
                    REG_STATUS:  dat_q <= status_w;
                    REG_CTRL:    dat_q <= {29'h0, irq_en_q, 1'b0, en_q};
                    default:     dat_q <= '0;
                endcase
            end
            if (wr) begin
                case (reg_sel)
                    REG_TX_DATA: if (tx_full) tx_ovf_q <= 1'b1;
                    REG_STATUS: begin
                        if (wbs_dat_i[ST_TX_OVF]) tx_ovf_q <= 1'b0;
                        if (wbs_dat_i[ST_RX_UNF]) rx_unf_q <= 1'b0;
                    end
                    REG_CTRL: if (wbs_sel_i[0]) begin
                        en_q     <= wbs_dat_i[CTRL_EN];
                        irq_en_q <= wbs_dat_i[CTRL_IRQ_EN];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_wb_serial_tl_bridge.sv
// Directed self-checking bench for wb_serial_tl_bridge (TL_W=8, DEPTH=8).
module tb_wb_serial_tl_bridge;

    localparam int          TL_W = 8;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] A_TX = BASE | 32'h0;
    localparam logic [31:0] A_RX = BASE | 32'h4;
    localparam logic [31:0] A_ST = BASE | 32'h8;
    localparam logic [31:0] A_CT = BASE | 32'hC;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]      sel = 4'h0;
    logic [31:0]     adr = '0, wdat = '0;
    logic            ack;
    logic [31:0]     rdat;
    logic            in_valid;
    logic            in_ready = 1'b0;
    logic [TL_W-1:0] in_bits;
    logic            out_valid = 1'b0;
    logic            out_ready;
    logic [TL_W-1:0] out_bits = '0;
    logic            irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_serial_tl_bridge #(.BASE_ADDR(BASE), .TL_W(TL_W), .DEPTH(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .serial_tl_bits_in_valid(in_valid), .serial_tl_bits_in_ready(in_ready),
        .serial_tl_bits_in_bits(in_bits),
        .serial_tl_bits_out_valid(out_valid), .serial_tl_bits_out_ready(out_ready),
        .serial_tl_bits_out_bits(out_bits),
        .irq(irq)
    );

    // Entered #1 after an edge (cycle N). Returns #1 after edge N+2.
    // Snapshots taken in N+1 (ack cycle) and N+2.
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd1, output logic ack1, output logic ack2,
                           output logic [31:0] rd2, output logic vin1, output logic rdy1,
                           output logic irq1);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = 4'hF;
        @(posedge clk); #1;
        ack1 = ack; rd1 = rdat; vin1 = in_valid; rdy1 = out_ready; irq1 = irq;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        ack2 = ack; rd2 = rdat;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r1, r2;
        logic        a1, a2, v1, y1, i1;
        wb_xfer(1'b1, a, d, r1, a1, a2, r2, v1, y1, i1);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        logic [31:0] r2;
        logic        a1, a2, v1, y1, i1;
        wb_xfer(1'b0, a, 32'h0, d, a1, a2, r2, v1, y1, i1);
    endtask

    // Drives the four beats of a word, LSB chunk first; reports any cycle where ready was low
    task automatic feed_word(input logic [31:0] w, output logic stalled);
        stalled = 1'b0;
        for (int j = 0; j < 4; j++) begin
            out_valid = 1'b1;
            out_bits  = w[j*8 +: 8];
            if (!out_ready) stalled = 1'b1;
            @(posedge clk); #1;
        end
        out_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] r1, r2;
        logic        a1, a2, v1, y1, i1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ack, rdat, in_valid, in_bits, out_ready, irq} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ack=%b dat=%h vin=%b bits=%h rdy=%b irq=%b expected all 0",
                     ack, rdat, in_valid, in_bits, out_ready, irq);
        end
        rst = 1'b0;
        wb_xfer(1'b0, A_ST, 32'h0, r1, a1, a2, r2, v1, y1, i1);
        checks++;
        if ({a1, a2} !== 2'b10) begin
            errors++; $display("FAIL ack_pulse: got ack N+1=%b N+2=%b expected 1,0", a1, a2);
        end
        checks++;
        if (r1 !== 32'h0000_000A) begin
            errors++; $display("FAIL reset_status: got %h expected 0000000a", r1);
        end
        checks++;
        if (r2 !== 32'h0) begin
            errors++; $display("FAIL dat_idle: got %h expected 00000000", r2);
        end
        wb_read(A_CT, r1);
        checks++;
        if (r1 !== 32'h0) begin
            errors++; $display("FAIL reset_ctrl: got %h expected 00000000", r1);
        end
    endtask

    task automatic test_decode;
        logic [31:0] r1, r2;
        logic        a1, a2, v1, y1, i1;
        wb_xfer(1'b0, BASE + 32'h10, 32'h0, r1, a1, a2, r2, v1, y1, i1);
        checks++;
        if (a1 !== 1'b0) begin
            errors++; $display("FAIL decode_miss_ack: got %b expected 0", a1);
        end
    endtask

    task automatic test_tx_serialise;
        logic [7:0] exp_b [4];
        exp_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        wb_write(A_CT, 32'h1);
        in_ready = 1'b1;
        wb_write(A_TX, 32'hA1B2_C3D4);   // now in cycle N+2
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (in_valid !== 1'b1 || in_bits !== exp_b[i]) begin
                errors++;
                $display("FAIL tx_beat%0d: got valid=%b bits=%h expected valid=1 bits=%h",
                         i, in_valid, in_bits, exp_b[i]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (in_valid !== 1'b0) begin
            errors++; $display("FAIL tx_done_valid: got %b expected 0", in_valid);
        end
    endtask

    task automatic test_tx_overflow;
        logic [31:0] r;
        wb_write(A_CT, 32'h0);
        for (int i = 0; i < 9; i++) wb_write(A_TX, 32'h100 + 32'(i));
        checks++;
        if (in_valid !== 1'b0) begin
            errors++; $display("FAIL tx_disabled_valid: got %b expected 0", in_valid);
        end
        wb_read(A_ST, r);
        checks++;
        if (r !== 32'h0000_0819) begin
            errors++; $display("FAIL tx_ovf_status: got %h expected 00000819", r);
        end
        wb_write(A_ST, 32'h10);
        wb_read(A_ST, r);
        checks++;
        if (r !== 32'h0000_0809) begin
            errors++; $display("FAIL tx_ovf_w1c: got %h expected 00000809", r);
        end
        wb_write(A_CT, 32'h2);
        wb_read(A_ST, r);
        checks++;
        if (r !== 32'h0000_000A) begin
            errors++; $display("FAIL tx_flush_status: got %h expected 0000000a", r);
        end
    endtask

    task automatic test_rx;
        logic [31:0] r;
        logic        st;
        wb_write(A_CT, 32'h1);
        feed_word(32'h1234_5678, st);   // returns in cycle M+1
        wb_read(A_ST, r);               // issued in M+1
        checks++;
        if (st !== 1'b0 || r !== 32'h0001_0002) begin
            errors++; $display("FAIL rx_status_after_word: got %h stall=%b expected 00010002 stall=0", r, st);
        end
        wb_read(A_RX, r);
        checks++;
        if (r !== 32'h1234_5678) begin
            errors++; $display("FAIL rx_data: got %h expected 12345678", r);
        end
        wb_read(A_RX, r);
        checks++;
        if (r !== 32'h0) begin
            errors++; $display("FAIL rx_empty_read: got %h expected 00000000", r);
        end
        wb_read(A_ST, r);
        checks++;
        if (r !== 32'h0000_002A) begin
            errors++; $display("FAIL rx_unf_status: got %h expected 0000002a", r);
        end
        wb_write(A_ST, 32'h20);
        wb_read(A_ST, r);
        checks++;
        if (r !== 32'h0000_000A) begin
            errors++; $display("FAIL rx_unf_w1c: got %h expected 0000000a", r);
        end
    endtask

    task automatic test_rx_full;
        logic [31:0] w, r1, r2;
        logic        st, any_st, a1, a2, v1, y1, i1;
        any_st = 1'b0;
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 4; j++) w[j*8 +: 8] = {4'(k), 4'(j)};
            feed_word(w, st);
            any_st = any_st | st;
        end
        checks++;
        if (any_st !== 1'b0 || out_ready !== 1'b0) begin
            errors++; $display("FAIL rx_full_ready: got ready=%b stall=%b expected ready=0 stall=0", out_ready, any_st);
        end
        wb_xfer(1'b0, A_RX, 32'h0, r1, a1, a2, r2, v1, y1, i1);
        checks++;
        if (r1 !== 32'h0302_0100 || y1 !== 1'b1) begin
            errors++; $display("FAIL rx_full_pop: got data=%h ready=%b expected 03020100 ready=1", r1, y1);
        end
        wb_read(A_ST, r1);
        checks++;
        if (r1 !== 32'h0007_0002) begin
            errors++; $display("FAIL rx_count7_status: got %h expected 00070002", r1);
        end
        wb_write(A_CT, 32'h3);
    endtask

    task automatic test_flush;
        logic [31:0] r1, r2;
        logic        a1, a2, v1, y1, i1;
        in_ready = 1'b1;
        wb_write(A_TX, 32'h1122_3344);
        checks++;
        if (in_valid !== 1'b1 || in_bits !== 8'h44) begin
            errors++; $display("FAIL flush_pre_beat0: got valid=%b bits=%h expected 1 44", in_valid, in_bits);
        end
        @(posedge clk); #1;
        checks++;
        if (in_valid !== 1'b1 || in_bits !== 8'h33) begin
            errors++; $display("FAIL flush_pre_beat1: got valid=%b bits=%h expected 1 33", in_valid, in_bits);
        end
        wb_xfer(1'b1, A_CT, 32'h3, r1, a1, a2, r2, v1, y1, i1);
        checks++;
        if (v1 !== 1'b0) begin
            errors++; $display("FAIL flush_valid_drop: got %b expected 0", v1);
        end
        wb_write(A_TX, 32'hAABB_CCDD);
        checks++;
        if (in_valid !== 1'b1 || in_bits !== 8'hDD) begin
            errors++; $display("FAIL flush_fresh_beat0: got valid=%b bits=%h expected 1 dd", in_valid, in_bits);
        end
        @(posedge clk); #1;
        checks++;
        if (in_bits !== 8'hCC) begin
            errors++; $display("FAIL flush_fresh_beat1: got %h expected cc", in_bits);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_irq_reset;
        logic [31:0] r1, r2;
        logic        st, a1, a2, v1, y1, i1;
        wb_write(A_CT, 32'h5);
        feed_word(32'hCAFE_F00D, st);   // cycle M+1
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_m1: got %b expected 0", irq);
        end
        @(posedge clk); #1;             // cycle M+2
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL irq_m2: got %b expected 1", irq);
        end
        wb_xfer(1'b0, A_RX, 32'h0, r1, a1, a2, r2, v1, y1, i1);
        checks++;
        if (r1 !== 32'hCAFE_F00D || i1 !== 1'b1 || irq !== 1'b0) begin
            errors++; $display("FAIL irq_pop: got data=%h irq N+1=%b N+2=%b expected cafef00d 1 0", r1, i1, irq);
        end
        // Build up state mid-word, then reset
        feed_word(32'h0BAD_BEEF, st);
        @(posedge clk); #1;
        wb_write(A_TX, 32'h5566_7788);
        out_valid = 1'b1;
        out_bits  = 8'h99;
        checks++;
        if (irq !== 1'b1 || in_valid !== 1'b1) begin
            errors++; $display("FAIL pre_reset_state: got irq=%b vin=%b expected 1 1", irq, in_valid);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({ack, rdat, in_valid, in_bits, out_ready, irq} !== '0) begin
            errors++;
            $display("FAIL midword_reset: got ack=%b dat=%h vin=%b bits=%h rdy=%b irq=%b expected all 0",
                     ack, rdat, in_valid, in_bits, out_ready, irq);
        end
        rst = 1'b0;
        out_valid = 1'b0;
        wb_read(A_ST, r1);
        checks++;
        if (r1 !== 32'h0000_000A) begin
            errors++; $display("FAIL post_reset_status: got %h expected 0000000a", r1);
        end
        wb_read(A_CT, r1);
        checks++;
        if (r1 !== 32'h0) begin
            errors++; $display("FAIL post_reset_ctrl: got %h expected 00000000", r1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_decode();
        test_tx_serialise();
        test_tx_overflow();
        test_rx();
        test_rx_full();
        test_flush();
        test_irq_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
